fetch_unit: RTL and testbench

Parametrised instruction-fetch unit: holds the fetch PC, issues requests to the external instruction memory over a req/gnt + rvalid interface, and buffers returned instructions in a DEPTH-entry in-order queue that feeds decode through a valid/ready handshake. A taken branch flushes the queue and all in-flight fetches, then redirects the PC to an absolute target or, optionally, a PC-relative one. Sits between the instruction memory (outside the SCC) and ID.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 79 +++++++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, queue entry layout and width helpers for the instruction-fetch unit.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEF  = 32'h0000_0004;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Counters must represent the full value DEPTH, hence one extra bit.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order DEPTH-entry fetch queue: slots are allocated at issue, filled in order by
// memory responses and popped in order by decode. Flush empties it in one cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      alloc,
  input  logic [ADDR_W-1:0]         alloc_pc,
  input  logic                      fill,
  input  logic [INSTR_W-1:0]        fill_data,
  input  logic                      pop,
  output logic                      head_valid,
  output logic [ADDR_W-1:0]         head_pc,
  output logic [INSTR_W-1:0]        head_instr,
  output logic [cnt_w(DEPTH)-1:0]   alloc_cnt,
  output logic [cnt_w(DEPTH)-1:0]   unfilled_cnt
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               filled;
  } entry_t;

  entry_t            slots [DEPTH];
  logic [PTR_W-1:0]  alloc_ptr;
  logic [PTR_W-1:0]  fill_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      alloc_ptr    <= '0;
      fill_ptr     <= '0;
      rd_ptr       <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (flush) begin
      alloc_ptr    <= '0;
      fill_ptr     <= '0;
      rd_ptr       <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) slots[i].filled <= 1'b0;
    end else begin
      // alloc, fill and pop always address distinct slots, so the writes never collide.
      if (alloc) begin
        slots[alloc_ptr].pc     <= alloc_pc;
        slots[alloc_ptr].filled <= 1'b0;
        alloc_ptr               <= alloc_ptr + PTR_W'(1);
      end
      if (fill) begin
        slots[fill_ptr].instr  <= fill_data;
        slots[fill_ptr].filled <= 1'b1;
        fill_ptr               <= fill_ptr + PTR_W'(1);
      end
      if (pop) begin
        slots[rd_ptr].filled <= 1'b0;
        rd_ptr               <= rd_ptr + PTR_W'(1);
      end
      alloc_cnt    <= alloc_cnt + CNT_W'(alloc) - CNT_W'(pop);
      unfilled_cnt <= unfilled_cnt + CNT_W'(alloc) - CNT_W'(fill);
    end
  end

  assign head_valid = slots[rd_ptr].filled;
  assign head_pc    = slots[rd_ptr].pc;
  assign head_instr = slots[rd_ptr].instr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch unit: fetch PC, imem req/gnt/rvalid issue, stale-response dropping
// after redirects. Optional PC-relative branch targets under FETCH_REL_BRANCH_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INSTR_W  = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0]  PC_STEP  = ADDR_W'(PC_STEP_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               taken,
  input  logic               branch_rel,
  input  logic [ADDR_W-1:0]  branch_address,
  input  logic [ADDR_W-1:0]  branch_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc
);

  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  target;
  logic [CNT_W-1:0]   drop_cnt;
  logic [CNT_W-1:0]   alloc_cnt;
  logic [CNT_W-1:0]   unfilled_cnt;
  logic [CNT_W-1:0]   pending;
  logic [CNT_W:0]     occupancy;
  logic               head_valid;
  logic [ADDR_W-1:0]  head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic               alloc;
  logic               fill;
  logic               pop;

`ifdef FETCH_REL_BRANCH_EN
  always_comb begin
    target = branch_address;
    if (branch_rel) target = branch_pc + branch_address;
  end
`else
  logic unused_rel;
  assign unused_rel = ^{branch_rel, branch_pc};
  always_comb begin
    target = branch_address;
  end
`endif

  assign occupancy   = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
  assign imem_req    = reset && !taken && (occupancy < (CNT_W + 1)'(DEPTH));
  assign imem_addr   = fetch_pc;
  assign alloc       = imem_req && imem_gnt;
  // Responses owed to flushed fetches are swallowed before any slot is filled.
  assign fill        = reset && !taken && imem_rvalid && (drop_cnt == '0) && (unfilled_cnt != '0);
  assign instr_valid = reset && !taken && head_valid;
  assign pop         = instr_valid && instr_ready;
  assign instruction = instr_valid ? head_instr : '0;
  assign pc          = instr_valid ? head_pc : '0;
  assign pending     = drop_cnt + unfilled_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (taken) begin
      fetch_pc <= target;
      drop_cnt <= pending - CNT_W'(imem_rvalid && (pending != '0));
    end else begin
      if (alloc) fetch_pc <= fetch_pc + PC_STEP;
      if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .flush        (taken),
    .alloc        (alloc),
    .alloc_pc     (fetch_pc),
    .fill         (fill),
    .fill_data    (imem_rdata),
    .pop          (pop),
    .head_valid   (head_valid),
    .head_pc      (head_pc),
    .head_instr   (head_instr),
    .alloc_cnt    (alloc_cnt),
    .unfilled_cnt (unfilled_cnt)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with an in-order fixed-latency memory model.
module tb_fetch_unit;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned DEPTH   = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               taken = 1'b0;
  logic               branch_rel = 1'b0;
  logic [ADDR_W-1:0]  branch_address = '0;
  logic [ADDR_W-1:0]  branch_pc = '0;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt = 1'b0;
  logic               imem_rvalid = 1'b0;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               instr_valid;
  logic               instr_ready = 1'b0;
  logic [INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0]  pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'h0000_0004)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .taken          (taken),
    .branch_rel     (branch_rel),
    .branch_address (branch_address),
    .branch_pc      (branch_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .pc             (pc)
  );

  // Memory model: grants recorded on posedge, response presented on the negedge
  // so that it is sampled mem_lat edges after the grant edge.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    int unsigned       t;
  } mreq_t;

  mreq_t       mq[$];
  int unsigned cyc = 0;
  int unsigned mem_lat = 1;

  function automatic logic [INSTR_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) begin
    mreq_t r;
    cyc++;
    if (!reset) begin
      mq.delete();
    end else if (imem_req && imem_gnt) begin
      r.addr = imem_addr;
      r.t    = cyc;
      mq.push_back(r);
    end
  end

  always @(negedge clk) begin
    if (mq.size() != 0 && (cyc - mq[0].t) >= (mem_lat - 1)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  task automatic start(input int unsigned lat, input logic g, input logic rdy);
    @(negedge clk);
    reset = 1'b0; taken = 1'b0; branch_rel = 1'b0;
    branch_address = '0; branch_pc = '0;
    imem_gnt = 1'b0; instr_ready = 1'b0; mem_lat = lat;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; imem_gnt = g; instr_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; taken = 1'b0; imem_gnt = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 00000000", imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    n_checks++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 00000000", instruction); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 00000000", pc); end
    @(negedge clk);
    reset = 1'b1; imem_gnt = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL release_req got %b exp 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL release_addr got %h exp 00000000", imem_addr); end
  endtask

  task automatic test_stream();
    logic [ADDR_W-1:0] exp_pc;
    start(1, 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req c=%0d got %b exp 1", c, imem_req); end
      n_checks++; if (imem_addr !== 32'(4 * c)) begin n_fail++; $display("FAIL stream_addr c=%0d got %h exp %h", c, imem_addr, 32'(4 * c)); end
      if (c >= 2) begin
        exp_pc = 32'(4 * (c - 2));
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid c=%0d got %b exp 1", c, instr_valid); end
        n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc c=%0d got %h exp %h", c, pc, exp_pc); end
        n_checks++; if (instruction !== mem_data(exp_pc)) begin n_fail++; $display("FAIL stream_instr c=%0d got %h exp %h", c, instruction, mem_data(exp_pc)); end
      end else begin
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid c=%0d got %b exp 0", c, instr_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    start(1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req got %b exp 0", imem_req); end
    n_checks++; if (instr_valid !== 1'b1 || pc !== 32'h0) begin n_fail++; $display("FAIL full_head got v=%b pc=%h exp v=1 pc=00000000", instr_valid, pc); end
    @(negedge clk);
    instr_ready = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL pop_same_cycle_req got %b exp 0", imem_req); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL pop0_pc got %h exp 00000000", pc); end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      if (k == 1) begin
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL resume_req got req=%b addr=%h exp req=1 addr=00000010", imem_req, imem_addr); end
      end
      n_checks++; if (instr_valid !== 1'b1 || pc !== 32'(4 * k)) begin n_fail++; $display("FAIL pop_pc k=%0d got v=%b pc=%h exp v=1 pc=%h", k, instr_valid, pc, 32'(4 * k)); end
      n_checks++; if (instruction !== mem_data(32'(4 * k))) begin n_fail++; $display("FAIL pop_instr k=%0d got %h exp %h", k, instruction, mem_data(32'(4 * k))); end
    end
  endtask

  task automatic test_gnt_stall();
    start(1, 1'b0, 1'b1);
    @(negedge clk); #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL stall_hold got req=%b addr=%h exp req=1 addr=00000000", imem_req, imem_addr); end
    @(negedge clk);
    imem_gnt = 1'b1;
    #1;
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL stall_grant_addr got %h exp 00000000", imem_addr); end
    @(negedge clk); #1;
    n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL stall_next_addr got %h exp 00000004", imem_addr); end
  endtask

  task automatic test_flush();
    start(3, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    taken = 1'b1; branch_rel = 1'b0; branch_address = 32'h100;
    #1;
    n_checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL taken_cycle got req=%b v=%b exp req=0 v=0", imem_req, instr_valid); end
    @(negedge clk);
    taken = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL redirect got req=%b addr=%h exp req=1 addr=00000100", imem_req, imem_addr); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stale_valid k=%0d got %b pc=%h exp 0", k, instr_valid, pc); end
    end
    @(negedge clk); #1;
    n_checks++; if (instr_valid !== 1'b1 || pc !== 32'h100) begin n_fail++; $display("FAIL flush_head got v=%b pc=%h exp v=1 pc=00000100", instr_valid, pc); end
    n_checks++; if (instruction !== mem_data(32'h100)) begin n_fail++; $display("FAIL flush_instr got %h exp %h", instruction, mem_data(32'h100)); end
  endtask

  task automatic test_rel_branch();
    logic [ADDR_W-1:0] exp_addr;
`ifdef FETCH_REL_BRANCH_EN
    exp_addr = 32'h0000_0030;
`else
    exp_addr = 32'hFFFF_FFF0;
`endif
    start(1, 1'b1, 1'b1);
    @(negedge clk);
    taken = 1'b1; branch_rel = 1'b1; branch_pc = 32'h40; branch_address = 32'hFFFF_FFF0;
    @(negedge clk);
    taken = 1'b0; branch_rel = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin n_fail++; $display("FAIL rel_target got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, exp_addr); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_a [4];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
    start(1, 1'b1, 1'b1);
    @(negedge clk);
    taken = 1'b1; branch_rel = 1'b0; branch_address = 32'hFFFF_FFF8;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      taken = 1'b0;
      #1;
      if (k < 4) begin
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== exp_a[k]) begin n_fail++; $display("FAIL wrap_addr k=%0d got req=%b addr=%h exp req=1 addr=%h", k, imem_req, imem_addr, exp_a[k]); end
      end
      if (k >= 2) begin
        n_checks++; if (instr_valid !== 1'b1 || pc !== exp_a[k-2]) begin n_fail++; $display("FAIL wrap_pc k=%0d got v=%b pc=%h exp v=1 pc=%h", k, instr_valid, pc, exp_a[k-2]); end
        n_checks++; if (instruction !== mem_data(exp_a[k-2])) begin n_fail++; $display("FAIL wrap_instr k=%0d got %h exp %h", k, instruction, mem_data(exp_a[k-2])); end
      end
    end
  endtask

  task automatic test_reset_mid();
    start(1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL midreset_req got req=%b addr=%h exp req=0 addr=00000000", imem_req, imem_addr); end
    n_checks++; if (instr_valid !== 1'b0 || instruction !== 32'h0 || pc !== 32'h0) begin n_fail++; $display("FAIL midreset_out got v=%b i=%h pc=%h exp all 0", instr_valid, instruction, pc); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL midreset_release got req=%b addr=%h exp req=1 addr=00000000", imem_req, imem_addr); end
    @(negedge clk); #1;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_early_valid got %b exp 0", instr_valid); end
    @(negedge clk); #1;
    n_checks++; if (instr_valid !== 1'b1 || pc !== 32'h0 || instruction !== mem_data(32'h0)) begin n_fail++; $display("FAIL midreset_first got v=%b pc=%h i=%h exp v=1 pc=00000000 i=%h", instr_valid, pc, instruction, mem_data(32'h0)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_gnt_stall();
    test_flush();
    test_rel_branch();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
